// File: rtl/fpa_rr_scheduler.sv
// Round-robin issue scheduler sharing one fixed-latency pipelined FP adder among NREQ requesters.
// A tag pipe that runs in step with the adder routes each result back to the requester that issued it.
module fpa_rr_scheduler #(
  parameter int NREQ       = 2,
  parameter int PIPE_DEPTH = 4,
  parameter int ID_W       = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int CNT_W      = $clog2(PIPE_DEPTH + 2) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*64-1:0] req_a,
  input  logic [NREQ*64-1:0] req_b,
  output logic               fpa_in_valid,
  output logic [63:0]        fpa_a,
  output logic [63:0]        fpa_b,
  input  logic [63:0]        fpa_result,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [63:0]        rsp_result,
  input  logic               drain,
  output logic               idle,
  output logic [CNT_W-1:0]   in_flight
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT} state_t;

  state_t                           state_q, state_d;
  logic                             idle_q, idle_d;
  logic [ID_W-1:0]                  ptr_q, ptr_d;
  logic                             fpa_in_valid_q, fpa_in_valid_d;
  logic [63:0]                      fpa_a_q, fpa_a_d;
  logic [63:0]                      fpa_b_q, fpa_b_d;
  logic [ID_W-1:0]                  issue_id_q, issue_id_d;
  logic [PIPE_DEPTH-1:0]            tag_vld_q, tag_vld_d;
  logic [PIPE_DEPTH-1:0][ID_W-1:0]  tag_id_q, tag_id_d;
  logic [NREQ-1:0]                  rsp_valid_q, rsp_valid_d;
  logic [63:0]                      rsp_result_q, rsp_result_d;
  logic [CNT_W-1:0]                 in_flight_q, in_flight_d;

  logic [NREQ-1:0]                  grant;
  logic [ID_W-1:0]                  grant_id;
  logic [ID_W-1:0]                  cand;
  logic                             grant_any;
  logic [63:0]                      op_a;
  logic [63:0]                      op_b;

  // Rotating-priority scan starting at ptr; reset also masks the combinational grant.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    cand      = '0;
    grant_any = 1'b0;
    ptr_d     = ptr_q;
    if (state_q == ST_RUN && rst_n) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = ID_W'((int'(ptr_q) + k) % NREQ);
        if (!grant_any && req_valid[cand]) begin
          grant_any   = 1'b1;
          grant[cand] = 1'b1;
          grant_id    = cand;
          ptr_d       = ID_W'((int'(ptr_q) + k + 1) % NREQ);
        end
      end
    end
  end

  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      op_a = op_a | (req_a[k*64 +: 64] & {64{grant[k]}});
      op_b = op_b | (req_b[k*64 +: 64] & {64{grant[k]}});
    end
  end

  always_comb begin
    fpa_in_valid_d = grant_any;
    fpa_a_d        = grant_any ? op_a : fpa_a_q;
    fpa_b_d        = grant_any ? op_b : fpa_b_q;
    issue_id_d     = grant_any ? grant_id : issue_id_q;

    // Tag pipe is fed from the issue register so its head lines up with fpa_result.
    tag_vld_d[0] = fpa_in_valid_q;
    tag_id_d[0]  = issue_id_q;
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
    end

    rsp_valid_d  = '0;
    rsp_result_d = rsp_result_q;
    if (tag_vld_q[PIPE_DEPTH-1]) begin
      rsp_valid_d[tag_id_q[PIPE_DEPTH-1]] = 1'b1;
      rsp_result_d                        = fpa_result;
    end

    in_flight_d = in_flight_q + CNT_W'(grant_any) - CNT_W'(|rsp_valid_q);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (drain) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!drain)                 state_d = ST_RUN;
        else if (in_flight_q == '0) state_d = ST_HALT;
      end
      ST_HALT:  if (!drain) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    idle_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      idle_q         <= 1'b0;
      ptr_q          <= '0;
      fpa_in_valid_q <= 1'b0;
      fpa_a_q        <= '0;
      fpa_b_q        <= '0;
      issue_id_q     <= '0;
      tag_vld_q      <= '0;
      tag_id_q       <= '0;
      rsp_valid_q    <= '0;
      rsp_result_q   <= '0;
      in_flight_q    <= '0;
    end else begin
      state_q        <= state_d;
      idle_q         <= idle_d;
      ptr_q          <= ptr_d;
      fpa_in_valid_q <= fpa_in_valid_d;
      fpa_a_q        <= fpa_a_d;
      fpa_b_q        <= fpa_b_d;
      issue_id_q     <= issue_id_d;
      tag_vld_q      <= tag_vld_d;
      tag_id_q       <= tag_id_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_result_q   <= rsp_result_d;
      in_flight_q    <= in_flight_d;
    end
  end

  assign req_ready    = grant;
  assign fpa_in_valid = fpa_in_valid_q;
  assign fpa_a        = fpa_a_q;
  assign fpa_b        = fpa_b_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign idle         = idle_q;
  assign in_flight    = in_flight_q;

endmodule

// File: tb/tb_fpa_rr_scheduler.sv
// Directed bench for fpa_rr_scheduler: a behavioural 4-deep adder stands in for the FP unit,
// and every expected value below is a hand-computed constant.
module tb_fpa_rr_scheduler;

  localparam int NREQ = 2;
  localparam int D    = 4;
  localparam logic [63:0] ONE   = 64'h3FF0000000000000;
  localparam logic [63:0] TWO   = 64'h4000000000000000;
  localparam logic [63:0] MTWO  = 64'hC000000000000000;
  localparam logic [63:0] R0    = 64'h4008000000000000;
  localparam logic [63:0] R1    = 64'h0000000000000000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*64-1:0] req_a;
  logic [NREQ*64-1:0] req_b;
  logic              fpa_in_valid;
  logic [63:0]       fpa_a, fpa_b, fpa_result;
  logic [NREQ-1:0]   rsp_valid;
  logic [63:0]       rsp_result;
  logic              drain = 1'b0;
  logic              idle;
  logic [3:0]        in_flight;

  int n_chk = 0;
  int n_err = 0;
  int cnt0 = 0, cnt1 = 0, mon_bad = 0;
  int peak = 0;
  logic peak_clr = 1'b0;
  int s0, s1, n;

  logic [63:0] add_pipe [D];

  fpa_rr_scheduler #(.NREQ(NREQ), .PIPE_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .fpa_in_valid(fpa_in_valid), .fpa_a(fpa_a),
    .fpa_b(fpa_b), .fpa_result(fpa_result), .rsp_valid(rsp_valid),
    .rsp_result(rsp_result), .drain(drain), .idle(idle), .in_flight(in_flight)
  );

  always #5 clk = ~clk;

  // Adder stand-in: result appears PIPE_DEPTH cycles after the issue cycle.
  always @(posedge clk) begin
    add_pipe[0] <= fpa_in_valid ? $realtobits($bitstoreal(fpa_a) + $bitstoreal(fpa_b))
                                : 64'hFFF80000DEADBEEF;
    for (int k = 1; k < D; k++) add_pipe[k] <= add_pipe[k-1];
  end
  assign fpa_result = add_pipe[D-1];

  // Operands never change, so each requester's result is a fixed constant.
  always @(negedge clk) begin
    if (peak_clr) peak <= 0;
    else if (int'(in_flight) > peak) peak <= int'(in_flight);
    if (rsp_valid[0]) begin
      cnt0 <= cnt0 + 1;
      if (rsp_result !== R0) mon_bad <= mon_bad + 1;
    end
    if (rsp_valid[1]) begin
      cnt1 <= cnt1 + 1;
      if (rsp_result !== R1) mon_bad <= mon_bad + 1;
    end
    if (rsp_valid == 2'b11) mon_bad <= mon_bad + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    req_a = {TWO, ONE};
    req_b = {MTWO, TWO};

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check_val("rst_ready", 64'(req_ready), 0);
    check_val("rst_fvld", 64'(fpa_in_valid), 0);
    check_val("rst_fa", fpa_a, 0);
    check_val("rst_rsp", 64'(rsp_valid), 0);
    check_val("rst_res", rsp_result, 0);
    check_val("rst_infl", 64'(in_flight), 0);
    check_val("rst_idle", 64'(idle), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single op from requester 0: 1.0 + 2.0
    req_valid = 2'b01;
    #1 check_val("s_ready", 64'(req_ready), 2'b01);
    tick();
    req_valid = 2'b00;
    check_val("s_fvld", 64'(fpa_in_valid), 1);
    check_val("s_fa", fpa_a, ONE);
    check_val("s_fb", fpa_b, TWO);
    check_val("s_infl", 64'(in_flight), 1);
    n = 0;
    while (rsp_valid == '0 && n < 20) begin tick(); n++; end
    check_val("s_lat", 64'(n), D + 1);
    check_val("s_rspv", 64'(rsp_valid), 2'b01);
    check_val("s_res", rsp_result, R0);
    tick();
    check_val("s_rsp_one", 64'(rsp_valid), 0);
    check_val("s_infl0", 64'(in_flight), 0);

    // Cancellation from requester 1: 2.0 + -2.0, pointer now at 1
    req_valid = 2'b11;
    #1 check_val("c_ready", 64'(req_ready), 2'b10);
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    n = 0;
    while (rsp_valid == '0 && n < 20) begin tick(); n++; end
    check_val("c_lat", 64'(n), D + 1);
    check_val("c_rspv", 64'(rsp_valid), 2'b10);
    check_val("c_res", rsp_result, R1);
    tick();

    // Fairness and steady-state issue/retire
    peak_clr = 1'b1;
    tick();
    peak_clr = 1'b0;
    s0 = cnt0; s1 = cnt1;
    req_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      #1 check_val($sformatf("f_grant%0d", k), 64'(req_ready), (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      if (k >= 5) check_val($sformatf("f_infl%0d", k), 64'(in_flight), D + 2);
    end
    req_valid = 2'b00;
    repeat (12) tick();
    check_val("f_cnt0", 64'(cnt0 - s0), 4);
    check_val("f_cnt1", 64'(cnt1 - s1), 4);
    check_val("f_peak", 64'(peak), D + 2);
    check_val("f_infl_end", 64'(in_flight), 0);

    // Drain with three ops in flight, the third issued in the cycle drain rises
    s0 = cnt0; s1 = cnt1;
    req_valid = 2'b11;
    #1 check_val("d_g0", 64'(req_ready), 2'b01);
    tick();
    check_val("d_g1", 64'(req_ready), 2'b10);
    tick();
    drain = 1'b1;
    #1 check_val("d_g2", 64'(req_ready), 2'b01);
    tick();
    check_val("d_ready0", 64'(req_ready), 0);
    check_val("d_infl3", 64'(in_flight), 3);
    check_val("d_notidle", 64'(idle), 0);
    n = 0;
    while (!idle && n < 30) begin tick(); n++; end
    check_val("d_idle_lat", 64'(n), 7);
    check_val("d_idle", 64'(idle), 1);
    check_val("d_rsps", 64'((cnt0 - s0) + (cnt1 - s1)), 3);
    check_val("d_infl0", 64'(in_flight), 0);
    drain = 1'b0;
    #1 check_val("d_halt_ready", 64'(req_ready), 0);
    tick();
    check_val("d_resume", 64'(req_ready), 2'b10);
    check_val("d_idle0", 64'(idle), 0);
    req_valid = 2'b00;
    repeat (10) tick();

    // Reset with four ops in flight
    req_valid = 2'b11;
    repeat (4) tick();
    check_val("r_infl4", 64'(in_flight), 4);
    #2 rst_n = 1'b0;
    #1;
    check_val("r_ready", 64'(req_ready), 0);
    check_val("r_fvld", 64'(fpa_in_valid), 0);
    check_val("r_fa", fpa_a, 0);
    check_val("r_fb", fpa_b, 0);
    check_val("r_rspv", 64'(rsp_valid), 0);
    check_val("r_res", rsp_result, 0);
    check_val("r_infl", 64'(in_flight), 0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    s0 = cnt0; s1 = cnt1;
    repeat (10) tick();
    check_val("r_norsp", 64'((cnt0 - s0) + (cnt1 - s1)), 0);
    check_val("r_infl_end", 64'(in_flight), 0);

    check_val("mon_rsp", 64'(mon_bad), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
